// File: rtl/rv32i_pkg.sv
// rv32i_pkg: arbiter state and owner types shared by the rv32i memory-side blocks
package rv32i_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_IF, ARB_D} arb_state_t;
  typedef enum logic {OWN_IF, OWN_D} arb_owner_t;
endpackage

// File: rtl/arb_watchdog.sv
// arb_watchdog: saturating busy-cycle counter that flags a missing memory response
// ports: clk, reset (async, active-high), clr (grant), inc (busy), timeout (count reaches TIMEOUT this cycle)
module arb_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic timeout
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TOP = CW'(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  // cnt_q holds the busy cycles already elapsed, so the current cycle is number cnt_q+1
  always_comb begin
    cnt_d = clr ? '0 : (inc && cnt_q != TOP) ? cnt_q + 1'b1 : cnt_q;
    timeout = inc && cnt_q == LAST;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one memory port between fetch and load/store
// ports: if_* fetch requester, d_* data requester, mem_* memory macro side; clk, reset (async, active-high)
module mem_port_arbiter
  import rv32i_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_err,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_err,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata
);
  arb_state_t state_q, state_d;
  arb_owner_t last_owner_q, last_owner_d;
  logic busy, grant, pick_d, timeout, done;
  logic [DATA_W-1:0] rsp_data;
  arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk(clk),
    .reset(reset),
    .clr(grant),
    .inc(busy),
    .timeout(timeout)
  );
  // reset gates every combinational output; a response coinciding with the timeout wins
  always_comb begin
    busy = state_q != ARB_IDLE;
    grant = !reset && !busy && (if_req || d_req);
    pick_d = d_req && (!if_req || last_owner_q == OWN_IF);
    done = !reset && busy && (mem_rvalid || timeout);
    rsp_data = mem_rvalid ? mem_rdata : '0;
    if_gnt = grant && !pick_d;
    d_gnt = grant && pick_d;
    mem_req = grant;
    mem_we = d_gnt && d_we;
    mem_be = d_gnt ? d_be : '0;
    mem_addr = d_gnt ? d_addr : if_gnt ? if_addr : '0;
    mem_wdata = d_gnt ? d_wdata : '0;
    if_rvalid = done && state_q == ARB_IF;
    d_rvalid = done && state_q == ARB_D;
    if_rdata = if_rvalid ? rsp_data : '0;
    d_rdata = d_rvalid ? rsp_data : '0;
    if_err = if_rvalid && !mem_rvalid;
    d_err = d_rvalid && !mem_rvalid;
    state_d = grant ? (pick_d ? ARB_D : ARB_IF) : done ? ARB_IDLE : state_q;
    last_owner_d = grant ? (pick_d ? OWN_D : OWN_IF) : last_owner_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= ARB_IDLE;
      last_owner_q <= OWN_IF;
    end else begin
      state_q <= state_d;
      last_owner_q <= last_owner_d;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized scoreboard bench with a transaction-level arbiter/memory model
module tb_mem_port_arbiter;
  localparam int AW = 32, DW = 32, BW = 4, TO = 16;
  logic clk = 0, reset = 1;
  logic if_req = 0;
  logic [AW-1:0] if_addr = 0;
  logic if_gnt, if_rvalid, if_err;
  logic [DW-1:0] if_rdata;
  logic d_req = 0, d_we = 0;
  logic [BW-1:0] d_be = 0;
  logic [AW-1:0] d_addr = 0;
  logic [DW-1:0] d_wdata = 0;
  logic d_gnt, d_rvalid, d_err;
  logic [DW-1:0] d_rdata;
  logic mem_req, mem_we;
  logic [BW-1:0] mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic mem_rvalid = 0;
  logic [DW-1:0] mem_rdata = 0;
  typedef struct {bit own_d; int due; logic [DW-1:0] data; bit err;} exp_t;
  exp_t sb[$];
  int vec = 0, bad = 0, cyc = 0, rv_at = -1, busy_until = -1, stray_at = -1;
  bit last_d = 0, rand_en = 0, force_never = 0;
  logic [DW-1:0] rv_data = 0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [127:0] all_outs();
    return 128'({if_gnt, if_rvalid, if_err, if_rdata, d_gnt, d_rvalid, d_err, d_rdata,
                 mem_req, mem_we, mem_be, mem_addr, mem_wdata});
  endfunction

  // transaction model: idle after the previous response, alternate on conflict, one memory latency per grant
  always @(negedge clk) begin
    if (reset) begin
      rv_at = -1;
      busy_until = -1;
      last_d = 0;
    end else if ((if_req || d_req) && cyc > busy_until) begin
      bit wd;
      int lat, r;
      exp_t e;
      wd = d_req && (!if_req || !last_d);
      last_d = wd;
      chk("grant", 128'({if_gnt, d_gnt, mem_req}), 128'({!wd, wd, 1'b1}));
      chk("mem_fields", 128'({mem_we, mem_be, mem_addr, wd ? mem_wdata : 32'h0}),
          wd ? 128'({d_we, d_be, d_addr, d_wdata}) : 128'({1'b0, 4'b0, if_addr, 32'h0}));
      r = $urandom_range(0, 9);
      lat = force_never ? 0 : r == 0 ? 0 : r == 1 ? TO : r == 2 ? TO - 1 : $urandom_range(1, 4);
      rv_data = $urandom;
      e.own_d = wd;
      e.err = lat == 0;
      e.due = cyc + (lat == 0 ? TO : lat);
      e.data = e.err ? '0 : rv_data;
      sb.push_back(e);
      busy_until = e.due;
      rv_at = lat != 0 ? cyc + lat : force_never ? cyc + TO + 3 : -1;
      if (force_never) stray_at = cyc + TO + 3;
    end else if (if_req || d_req)
      chk("no_grant_busy", 128'({if_gnt, d_gnt, mem_req}), 128'(0));
  end

  always @(posedge clk) begin
    #1;
    mem_rvalid = cyc == rv_at;
    mem_rdata = mem_rvalid ? rv_data : $urandom;
  end

  always @(negedge clk) begin
    if (reset) sb.delete();
    else if (sb.size() > 0 && sb[0].due == cyc) begin
      exp_t e;
      e = sb.pop_front();
      chk("response", 128'({if_rvalid, if_err, if_rdata, d_rvalid, d_err, d_rdata}),
          e.own_d ? 128'({1'b0, 1'b0, 32'h0, 1'b1, e.err, e.data})
                  : 128'({1'b1, e.err, e.data, 1'b0, 1'b0, 32'h0}));
    end else if (if_rvalid || d_rvalid || if_err || d_err)
      chk("spurious_rvalid", 128'({if_rvalid, if_err, d_rvalid, d_err}), 128'(0));
  end

  task automatic step();
    logic ig, dg;
    @(negedge clk);
    ig = if_gnt;
    dg = d_gnt;
    @(posedge clk);
    #1;
    if (ig) if_req = 0;
    if (dg) d_req = 0;
    if (rand_en && !if_req && $urandom_range(0, 2) == 0) begin
      if_req = 1;
      if_addr = $urandom & 32'hFFFF_FFFC;
    end
    if (rand_en && !d_req && $urandom_range(0, 2) == 0) begin
      d_req = 1;
      d_we = 1'($urandom);
      d_be = 4'($urandom);
      d_addr = $urandom;
      d_wdata = $urandom;
    end
  endtask

  task automatic drain(string name);
    int n;
    n = 0;
    while ((if_req || d_req || sb.size() > 0) && n < 300) begin
      step();
      n++;
    end
    chk({name, "_drain"}, 128'(n < 300), 128'(1));
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    if_req = 1;
    if_addr = 32'h10;
    d_req = 1;
    d_addr = 32'h100;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", all_outs(), 128'(0));
    reset = 0;
    rand_en = 1;
    repeat (600) step();
    rand_en = 0;
    drain("random");
    if_req = 1;
    if_addr = 32'h10;
    @(negedge clk);
    @(posedge clk);
    #1;
    if_req = 0;
    reset = 1;
    d_req = 1;
    d_we = 0;
    d_addr = 32'h40;
    #1;
    chk("reset_midflight", all_outs(), 128'(0));
    @(posedge clk);
    #1;
    reset = 0;
    drain("after_reset");
    force_never = 1;
    d_req = 1;
    d_we = 0;
    d_addr = 32'h80;
    step();
    force_never = 0;
    drain("timeout");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (cyc >= stray_at) break;
    end
    chk("stray_reached", 128'(cyc == stray_at), 128'(1));
    chk("stray_ignored", 128'({if_rvalid, if_err, d_rvalid, d_err, if_gnt, d_gnt}), 128'(0));
    @(posedge clk);
    #1;
    if_req = 1;
    if_addr = 32'h20;
    drain("post_stray");
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-ported unified memory between the instruction-fetch path and the load/store path of the rv32i core. The arbiter grants one requester per transaction and keeps at most one transaction outstanding. It steers returned read data to the owning requester and ends any transaction the memory never answers by raising an error. It sits between the datapath's fetch and data ports and the memory macro, and lets instruction and data share one memory array.

## Interface
- `ADDR_W`, 32: address width, byte address.
- `DATA_W`, 32: data width; byte enables are `DATA_W/8` bits wide.
- `TIMEOUT`, 16: maximum number of cycles to wait for `mem_rvalid`; must be ≥ 2.
- `clk` in 1: the single clock; everything is sampled on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `if_req` in 1: fetch read request; held with `if_addr` stable until `if_gnt`.
- `if_addr` in `ADDR_W`: fetch address.
- `if_gnt` out 1: fetch request accepted this cycle.
- `if_rvalid` out 1: `if_rdata` is valid this cycle.
- `if_rdata` out `DATA_W`: fetch read data.
- `if_err` out 1: fetch transaction timed out; pulses together with `if_rvalid`.
- `d_req` in 1: data request; held with its fields stable until `d_gnt`.
- `d_we` in 1: 1 = store, 0 = load.
- `d_be` in `DATA_W/8`: byte enables for a store.
- `d_addr` in `ADDR_W`: data address.
- `d_wdata` in `DATA_W`: store data.
- `d_gnt` out 1: data request accepted this cycle.
- `d_rvalid` out 1: data transaction complete; also pulses for stores.
- `d_rdata` out `DATA_W`: load data.
- `d_err` out 1: data transaction timed out.
- `mem_req` out 1: memory request.
- `mem_we` out 1: memory write enable.
- `mem_be` out `DATA_W/8`: memory byte enables.
- `mem_addr` out `ADDR_W`: memory address.
- `mem_wdata` out `DATA_W`: memory write data.
- `mem_rvalid` in 1: memory response; asserted once per accepted request, at least 1 cycle after it.
- `mem_rdata` in `DATA_W`: memory read data.

## Operation
- State machine states: `ARB_IDLE`, `ARB_IF` (fetch owns the memory), `ARB_D` (data owns the memory).
- In `ARB_IDLE` with at least one request asserted, the arbiter picks a winner.
  - It drives `mem_req=1` and the winner's fields combinationally, and asserts the winner's `gnt` in the same cycle.
  - For a fetch, `mem_we=0` and `mem_be=0`.
  - On the next edge the state moves to `ARB_IF` or `ARB_D`.
- Conflict (`if_req & d_req` in `ARB_IDLE`): round-robin. The requester that did *not* win the previous grant wins, as recorded in the register `last_owner`. Neither requester can be starved.
- In `ARB_IF`/`ARB_D`:
  - `mem_req=0`; both `gnt` outputs are 0.
  - On `mem_rvalid`, the owner's `rvalid=1` and its `rdata=mem_rdata`, combinational pass-through. The next state is `ARB_IDLE`.
- Watchdog: a counter clears on every grant and increments each cycle in a busy state. When the count reaches `TIMEOUT` without `mem_rvalid`:
  - the owner's `rvalid=1`, `err=1` and `rdata=0`;
  - the next state is `ARB_IDLE`.
- `mem_rvalid` is ignored in `ARB_IDLE`, which covers a late response after a timeout.
- Non-owner `rvalid`, `rdata` and `err` are always 0.
- Reset:
  - asynchronous; state goes to `ARB_IDLE`, the counter to 0, and `last_owner` to fetch, so the first conflict grants data;
  - all outputs are forced to 0 while `reset=1`, including the combinational `gnt` and `mem_*` outputs;
  - a reset during a busy state abandons the transaction, and no `rvalid` is issued.

## Timing
- Grant latency: 0 cycles from `req` in `ARB_IDLE`.
- Response latency: memory latency + 0 cycles, with no registering of response data.
- The earliest next grant is the cycle after `rvalid`, since the arbiter must be back in `ARB_IDLE`. Peak throughput is one transaction per (memory latency + 1) cycles.
- If `mem_rvalid` and the timeout fall in the same cycle, it is a normal completion: `err=0` and the data is passed through.
- A request newly raised in a busy state waits; it is not lost provided the requester holds it.
- Counter width is `$clog2(TIMEOUT+1)`. It saturates and never wraps.

## Structure
- Put `arb_state_t` (`ARB_IDLE`, `ARB_IF`, `ARB_D`) and `arb_owner_t` (`OWN_IF`, `OWN_D`) in the shared package `rv32i_pkg`.
- One sub-module is natural: `arb_watchdog`, holding the clear/increment/saturating counter and a `timeout` output.
- The winner-select mux and the response steering stay inline.

## Test plan
- Fetch only: `if_req=1`, `if_addr=0x10`, memory latency 2, `mem_rdata=0x00500093` → `if_gnt` in cycle 0; `if_rvalid=1` with `if_rdata=0x00500093` in cycle 2; `d_rvalid` stays 0.
- Store: `d_req=1`, `d_we=1`, `d_be=4'b0011`, `d_addr=0x200`, `d_wdata=0xDEADBEEF` → in cycle 0 `mem_we=1`, `mem_be=0011`, `mem_addr=0x200`, `mem_wdata=0xDEADBEEF`; `d_rvalid` pulses on `mem_rvalid`.
- Simultaneous requests held for 3 transactions after reset → grant order data, fetch, data; no two consecutive grants to the same requester.
- Memory never responds with `TIMEOUT=16` → `d_rvalid=1`, `d_err=1`, `d_rdata=0` exactly 16 cycles after the grant. A stray `mem_rvalid` 3 cycles later produces no output.
- `reset` asserted 1 cycle after an `if_gnt` → outputs go to 0 immediately. After release, a new `d_req` is granted with no `if_rvalid` ever seen.
- `mem_rvalid` arrives in the same cycle the count reaches `TIMEOUT` → `rvalid=1`, `err=0`, data passed through.
